merger_out_coupler: RTL
=======================

# merger_out_coupler

Downstream stage of the 4-tuple merger tree root. It accepts the merged 128-bit tuple stream from the merger's output port and packs RATIO consecutive tuples into one wide beat for the memory-write path. An end-of-run terminator forces an early flush with zero padding and marks that beat last. Its ready output drives the merger's `i_fifo_out_ready`, which the merger registers before use, so the block absorbs one extra write after dropping ready.

## Interface
- DATA_WIDTH, 128, width of one tuple (four 32-bit records, key in bits [31:0])
- RATIO, 4, tuples per output beat (power of two, ≥2)
- SKID_DEPTH, 4, input skid FIFO entries (≥3)
- i_clk  in  1  clock, all logic on rising edge
- i_rst  in  1  reset; one clock, synchronous and active-high
- i_data  in  DATA_WIDTH  tuple from merger `o_data`
- i_write  in  1  tuple valid, from merger `o_out_fifo_write`
- o_ready  out  1  space available; to merger `i_fifo_out_ready`
- o_data  out  DATA_WIDTH*RATIO  packed beat, lane k at [k*DATA_WIDTH +: DATA_WIDTH]
- o_valid  out  1  beat valid
- i_ready  in  1  downstream accepts beat
- o_last  out  1  beat closes a run (contains terminator)
- o_beat_count  out  32  beats accepted downstream, wraps at 2^32
- o_run_count  out  32  terminators emitted, wraps
- o_overrun  out  1  sticky: write arrived while skid FIFO full

## Operation
- Terminator: tuple with i_data[31:0]==0.
- Skid FIFO: i_write pushes i_data. Push while full is dropped and sets o_overrun until reset.
- o_ready = !i_rst && occupancy ≤ SKID_DEPTH-2. Because the merger registers ready, a write in cycle t is legal iff o_ready was 1 in cycle t-1. Under that rule the FIFO never overflows.
- Packer holds an assembly register plus a lane counter (0..RATIO-1).
- A pop places the head tuple in the current lane. A pop is completing if lane==RATIO-1 or the tuple is a terminator.
- A non-completing pop occurs whenever the FIFO is non-empty. It increments the lane.
- A completing pop requires the output slot free (o_valid==0 or i_ready==1 in the same cycle). It loads the output register on that edge and sets lane to 0.
- The loaded beat contains the assembled lanes plus the current tuple, with all higher lanes zero.
- o_last = 1 iff the completing tuple was a terminator.
- On a terminator beat, o_run_count increments at the load edge. o_beat_count increments on each o_valid&&i_ready.
- Output register: o_data and o_last hold steady while o_valid&&!i_ready. o_valid clears after acceptance unless a new beat loads on the same edge.
- Data order is preserved. There is at most one pop per cycle.

## Timing
- Reset values: o_valid=0, o_last=0, o_data=0, o_beat_count=0, o_run_count=0, o_overrun=0, o_ready=0 during reset and 1 in the first cycle after it. The FIFO is emptied and lane=0.
- Writes during reset are ignored. Reset mid-beat discards the partial assembly and any unaccepted beat.
- Latency: the tuple written in cycle t is poppable at t+1. If it completes a beat, o_valid=1 at t+2.
- Sustained throughput is 1 tuple/cycle in and 1 beat/RATIO cycles out with i_ready=1. There are no bubbles on back-to-back beats.
- Simultaneous push and pop on the same edge keeps occupancy unchanged, including at full-1.
- Downstream stall: completing pops block, the FIFO fills, and o_ready drops at occupancy SKID_DEPTH-1. The in-flight write is absorbed into the last slot.
- Terminator in lane 0 yields a beat with only lane 0 populated, o_last=1.

## Structure
- Shared package bonsai_pkg: KEY_WIDTH=32, default DATA_WIDTH, function is_terminator(tuple) returning key==0. The merger and this block both use it.
- One sub-module: coupler_skid_fifo (parameterised width/depth, registered occupancy, full/empty/occupancy outputs). The packer and counters live in the top.

## Test plan
- Stream tuples keys 1..8 (RATIO=4), i_ready=1 → two beats with keys 1,2,3,4 and 5,6,7,8 in lanes 0..3. First o_valid exactly 2 cycles after the 4th write. o_beat_count=2, o_last=0.
- Keys 5,6 then terminator (key 0) → one beat with lanes 5,6,0 and lane 3 all-zero, o_last=1, o_run_count=1.
- Hold i_ready=0 and write whenever the registered o_ready allows → o_ready falls at occupancy 3. Exactly one further write is absorbed, o_overrun stays 0, and o_data is unchanged while stalled. Releasing i_ready delivers all data in order.
- Force a write while the FIFO is full → o_overrun=1 and stays 1 until i_rst. The dropped tuple never appears on o_data.
- Assert i_rst after 2 of 4 tuples → o_valid=0 and counters=0. Next 4 tuples form a clean beat without the stale lanes.
- Randomised i_ready with 1000 tuples and a terminator every 7 → output equals the reference packing model. o_run_count matches the terminator count, and no o_overrun.

Source files
------------

// File: rtl/bonsai_pkg.sv
// ---------------------------------------------------------------------------
// bonsai_pkg : shared tuple widths and terminator test for the merger tree
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package bonsai_pkg;

  localparam int KEY_WIDTH   = 32;
  localparam int TUPLE_WIDTH = 128;

  typedef logic [TUPLE_WIDTH-1:0] tuple_t;

  // A zero key marks the end of a sorted run.
  function automatic logic is_terminator(input logic [KEY_WIDTH-1:0] key);
    return key == '0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/coupler_skid_fifo.sv
// ---------------------------------------------------------------------------
// coupler_skid_fifo : small circular skid buffer with registered occupancy
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module coupler_skid_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 4,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] occupancy
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign occupancy = count;
  assign head      = mem[rd_ptr];

  // A push into a full buffer is dropped even if a pop happens on the same edge.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/merger_out_coupler.sv
// ---------------------------------------------------------------------------
// merger_out_coupler : packs RATIO merged tuples per wide beat, flushing early
//                      with zero padding on a run terminator
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module merger_out_coupler
  import bonsai_pkg::*;
#(
  parameter int DATA_WIDTH = TUPLE_WIDTH,
  parameter int RATIO      = 4,
  parameter int SKID_DEPTH = 4
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [DATA_WIDTH-1:0]       i_data,
  input  logic                        i_write,
  output logic                        o_ready,
  output logic [DATA_WIDTH*RATIO-1:0] o_data,
  output logic                        o_valid,
  input  logic                        i_ready,
  output logic                        o_last,
  output logic [31:0]                 o_beat_count,
  output logic [31:0]                 o_run_count,
  output logic                        o_overrun
);

  localparam int LANE_W = $clog2(RATIO);
  localparam int OCC_W  = $clog2(SKID_DEPTH + 1);
  localparam int BEAT_W = DATA_WIDTH * RATIO;

  logic [DATA_WIDTH-1:0] head;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [OCC_W-1:0]      occupancy;
  logic                  push;
  logic                  pop;
  logic                  head_term;
  logic                  completing;
  logic                  slot_free;
  logic                  load;
  logic [LANE_W-1:0]     lane;
  logic [BEAT_W-1:0]     assembly;
  logic [BEAT_W-1:0]     beat_next;

  coupler_skid_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (SKID_DEPTH)
  ) u_skid (
    .clk       (i_clk),
    .rst       (i_rst),
    .push      (push),
    .push_data (i_data),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .occupancy (occupancy)
  );

  // The merger registers ready, so one slot of headroom absorbs its in-flight write.
  assign o_ready = !i_rst && (occupancy <= OCC_W'(SKID_DEPTH - 2));
  assign push    = i_write && !i_rst;

  assign head_term  = is_terminator(head[KEY_WIDTH-1:0]);
  assign completing = (lane == LANE_W'(RATIO - 1)) || head_term;
  assign slot_free  = !o_valid || i_ready;
  assign pop        = !fifo_empty && (!completing || slot_free);
  assign load       = pop && completing;

  // Lanes above the current one are masked to zero, so stale assembly never leaks.
  for (genvar k = 0; k < RATIO; k++) begin : g_lane
    assign beat_next[k*DATA_WIDTH +: DATA_WIDTH] =
        (LANE_W'(k) < lane)  ? assembly[k*DATA_WIDTH +: DATA_WIDTH] :
        (LANE_W'(k) == lane) ? head : '0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      lane         <= '0;
      assembly     <= '0;
      o_data       <= '0;
      o_valid      <= 1'b0;
      o_last       <= 1'b0;
      o_beat_count <= '0;
      o_run_count  <= '0;
      o_overrun    <= 1'b0;
    end else begin
      if (pop && !completing) begin
        assembly[lane*DATA_WIDTH +: DATA_WIDTH] <= head;
        lane <= lane + LANE_W'(1);
      end

      if (load) begin
        o_data  <= beat_next;
        o_last  <= head_term;
        o_valid <= 1'b1;
        lane    <= '0;
        if (head_term) begin
          o_run_count <= o_run_count + 32'd1;
        end
      end else if (i_ready) begin
        o_valid <= 1'b0;
      end

      if (o_valid && i_ready) begin
        o_beat_count <= o_beat_count + 32'd1;
      end

      if (i_write && fifo_full) begin
        o_overrun <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire
